// File: rtl/dlsc_pcie_s6_outbound_cmd_pkg.sv
// Shared definitions for the outbound command front-end.
//   MRD32/MRD64/MWR32/MWR64 : TLP fmt[1:0],type[4:0] codes
//   state_t                 : front-end FSM states
//   fmt_type()              : selects the TLP code from direction and address size
package dlsc_pcie_s6_outbound_cmd_pkg;

  localparam logic [6:0] MRD32 = 7'h00;
  localparam logic [6:0] MRD64 = 7'h20;
  localparam logic [6:0] MWR32 = 7'h40;
  localparam logic [6:0] MWR64 = 7'h60;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XLAT,
    ST_OUT
  } state_t;

  function automatic logic [6:0] fmt_type(input logic write, input logic is64);
    logic [6:0] f;
    case ({write, is64})
      2'b00:   f = MRD32;
      2'b01:   f = MRD64;
      2'b10:   f = MWR32;
      default: f = MWR64;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/dlsc_pcie_s6_outbound_cmd_if.sv
// Command channel carrying one AXI-derived request (write or read side).
//   valid/ready : handshake
//   addr        : DW address [ADDR-1:2]
//   len         : DW count (0 is illegal)
//   first_be    : first-DW byte enables
//   last_be     : last-DW byte enables
// master = command source, slave = command sink.
interface dlsc_pcie_s6_outbound_cmd_if #(
  parameter int ADDR = 32,
  parameter int LEN  = 4
);
  logic            valid;
  logic            ready;
  logic [ADDR-3:0] addr;
  logic [LEN-1:0]  len;
  logic [3:0]      first_be;
  logic [3:0]      last_be;

  modport master (output valid, addr, len, first_be, last_be, input ready);
  modport slave  (input valid, addr, len, first_be, last_be, output ready);
endinterface

// File: rtl/dlsc_rr_arbiter2.sv
// Two-input round-robin arbiter.
//   clk, rst_n        : clock, synchronous active-low reset
//   i_en              : arbitration allowed this cycle
//   i_req_a, i_req_b  : requests (a = write side, b = read side)
//   o_grant_a/b       : one-hot grant; a grant is also the accept
// With both requesting, the side not served last wins; after reset side a wins.
module dlsc_rr_arbiter2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_req_a,
  input  logic i_req_b,
  output logic o_grant_a,
  output logic o_grant_b
);

  logic r_prio_b;

  always_comb begin
    o_grant_a = i_en && i_req_a && (!i_req_b || !r_prio_b);
    o_grant_b = i_en && i_req_b && (!i_req_a ||  r_prio_b);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prio_b <= 1'b0;
    end else if (o_grant_a) begin
      r_prio_b <= 1'b1;
    end else if (o_grant_b) begin
      r_prio_b <= 1'b0;
    end
  end

endmodule

// File: rtl/dlsc_pcie_s6_outbound_cmd.sv
// Outbound command front-end: arbitrates write/read commands, runs the
// address-translator handshake, and presents a TLP-ready command.
//   clk, rst_n          : clock, synchronous active-low reset
//   wr_cmd, rd_cmd      : command channels (slave side)
//   o_trans_req(_addr)  : translation request, held until ack
//   i_trans_ack(_addr/_64) : translation result, valid in the ack cycle only
//   o_out_*, i_out_ready: command to the TLP header builder
module dlsc_pcie_s6_outbound_cmd
  import dlsc_pcie_s6_outbound_cmd_pkg::*;
#(
  parameter int ADDR = 32,
  parameter int LEN  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  dlsc_pcie_s6_outbound_cmd_if.slave   wr_cmd,
  dlsc_pcie_s6_outbound_cmd_if.slave   rd_cmd,
  output logic                         o_trans_req,
  output logic [ADDR-3:0]              o_trans_req_addr,
  input  logic                         i_trans_ack,
  input  logic [61:0]                  i_trans_ack_addr,
  input  logic                         i_trans_ack_64,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [6:0]                   o_out_fmt_type,
  output logic [9:0]                   o_out_len,
  output logic [3:0]                   o_out_first_be,
  output logic [3:0]                   o_out_last_be,
  output logic [61:0]                  o_out_addr,
  output logic                         o_out_write
);

  state_t          r_state;
  state_t          w_state_next;
  logic            w_grant_wr;
  logic            w_grant_rd;
  logic            w_accept;
  logic [ADDR-3:0] w_addr;
  logic [LEN-1:0]  w_len;
  logic [3:0]      w_first_be;
  logic [3:0]      w_last_be;

  logic [ADDR-3:0] r_addr;
  logic [LEN-1:0]  r_len;
  logic [3:0]      r_first_be;
  logic [3:0]      r_last_be;
  logic            r_write;
  logic [61:0]     r_ack_addr;
  logic            r_ack_64;

  // Gating with rst_n keeps both readies low while reset is held.
  dlsc_rr_arbiter2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      ((r_state == ST_IDLE) && rst_n),
    .i_req_a   (wr_cmd.valid),
    .i_req_b   (rd_cmd.valid),
    .o_grant_a (w_grant_wr),
    .o_grant_b (w_grant_rd)
  );

  assign wr_cmd.ready = w_grant_wr;
  assign rd_cmd.ready = w_grant_rd;
  // A grant only occurs on a valid request, so it is the handshake.
  assign w_accept     = w_grant_wr | w_grant_rd;

  always_comb begin
    w_addr     = w_grant_wr ? wr_cmd.addr     : rd_cmd.addr;
    w_len      = w_grant_wr ? wr_cmd.len      : rd_cmd.len;
    w_first_be = w_grant_wr ? wr_cmd.first_be : rd_cmd.first_be;
    w_last_be  = w_grant_wr ? wr_cmd.last_be  : rd_cmd.last_be;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)                   w_state_next = ST_XLAT;
      ST_XLAT: if (i_trans_ack)                w_state_next = ST_OUT;
      ST_OUT:  if (i_out_ready)                w_state_next = ST_IDLE;
      default:                                 w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath registers carry no reset: they are only observed once the
  // FSM has loaded them.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr     <= w_addr;
      r_len      <= w_len;
      r_first_be <= w_first_be;
      // A single-DW TLP must carry a zero last-DW byte enable.
      r_last_be  <= (w_len == LEN'(1)) ? 4'h0 : w_last_be;
      r_write    <= w_grant_wr;
    end
    if ((r_state == ST_XLAT) && i_trans_ack) begin
      r_ack_addr <= i_trans_ack_addr;
      r_ack_64   <= i_trans_ack_64;
    end
  end

  assign o_trans_req      = (r_state == ST_XLAT);
  assign o_trans_req_addr = r_addr;
  assign o_out_valid      = (r_state == ST_OUT);
  assign o_out_fmt_type   = fmt_type(r_write, r_ack_64);
  assign o_out_len        = 10'(r_len);
  assign o_out_first_be   = r_first_be;
  assign o_out_last_be    = r_last_be;
  assign o_out_addr       = r_ack_addr;
  assign o_out_write      = r_write;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(i_trans_ack && (r_state != ST_XLAT)));
      if (w_accept) begin
        assert (w_len != '0);
      end
    end
  end

endmodule

// File: tb/tb_dlsc_pcie_s6_outbound_cmd.sv
module tb_dlsc_pcie_s6_outbound_cmd;

  localparam int ADDR = 32;
  localparam int LEN  = 4;

  typedef struct {
    logic [6:0]  fmt;
    logic [9:0]  len;
    logic [3:0]  fbe;
    logic [3:0]  lbe;
    logic [61:0] addr;
    logic        wr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dlsc_pcie_s6_outbound_cmd_if #(.ADDR(ADDR), .LEN(LEN)) wr_if ();
  dlsc_pcie_s6_outbound_cmd_if #(.ADDR(ADDR), .LEN(LEN)) rd_if ();

  logic            trans_req;
  logic [ADDR-3:0] trans_req_addr;
  logic            trans_ack;
  logic [61:0]     trans_ack_addr;
  logic            trans_ack_64;
  logic            out_valid;
  logic            out_ready;
  logic [6:0]      out_fmt_type;
  logic [9:0]      out_len;
  logic [3:0]      out_first_be;
  logic [3:0]      out_last_be;
  logic [61:0]     out_addr;
  logic            out_write;

  dlsc_pcie_s6_outbound_cmd #(.ADDR(ADDR), .LEN(LEN)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .wr_cmd           (wr_if),
    .rd_cmd           (rd_if),
    .o_trans_req      (trans_req),
    .o_trans_req_addr (trans_req_addr),
    .i_trans_ack      (trans_ack),
    .i_trans_ack_addr (trans_ack_addr),
    .i_trans_ack_64   (trans_ack_64),
    .o_out_valid      (out_valid),
    .i_out_ready      (out_ready),
    .o_out_fmt_type   (out_fmt_type),
    .o_out_len        (out_len),
    .o_out_first_be   (out_first_be),
    .o_out_last_be    (out_last_be),
    .o_out_addr       (out_addr),
    .o_out_write      (out_write)
  );

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          tr_delay = 2;
  logic [61:0] tr_off = '0;
  logic        tr_64 = 1'b0;
  int          rdy_delay = 0;
  int          n_out = 0;

  // translator / monitor private state
  int              tr_cnt = 0;
  logic [ADDR-3:0] tr_snap;
  int              mon_vc = 0;
  bit              mon_pend_idle = 1'b0;
  logic [61:0]     mon_snap_addr;
  logic [29:0]     mon_snap_rest;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input bit wr, input logic [29:0] a, input logic [3:0] len,
                              input logic [3:0] fbe, input logic [3:0] lbe);
    exp_t e;
    e.fmt  = wr ? (tr_64 ? 7'h60 : 7'h40) : (tr_64 ? 7'h20 : 7'h00);
    e.len  = {6'b0, len};
    e.fbe  = fbe;
    e.lbe  = (len == 4'd1) ? 4'h0 : lbe;
    e.addr = {32'b0, a} + tr_off;
    e.wr   = wr;
    return e;
  endfunction

  // Translator model: acks tr_delay+1 negedges after first seeing a request.
  initial begin
    trans_ack = 1'b0;
    trans_ack_addr = '0;
    trans_ack_64 = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (trans_ack) begin
        trans_ack = 1'b0;
        tr_cnt = 0;
        chk("trans_req_fall", 64'(trans_req), 64'(0));
      end else if (trans_req) begin
        tr_cnt++;
        if (tr_cnt == 1) tr_snap = trans_req_addr;
        else chk("req_addr_stable", 64'(trans_req_addr), 64'(tr_snap));
        if (tr_cnt == tr_delay + 1) begin
          trans_ack = 1'b1;
          trans_ack_addr = {32'b0, tr_snap} + tr_off;
          trans_ack_64 = tr_64;
        end
      end else begin
        tr_cnt = 0;
      end
    end
  end

  // Output monitor: holds out_ready low rdy_delay cycles, then pops the scoreboard.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (mon_pend_idle) begin
        mon_pend_idle = 1'b0;
        chk("out_valid_drop", 64'(out_valid), 64'(0));
        if (wr_if.valid || rd_if.valid)
          chk("next_grant", 64'(wr_if.ready | rd_if.ready), 64'(1));
      end
      if (out_valid) begin
        mon_vc++;
        chk("cmd_ready_low", 64'({wr_if.ready, rd_if.ready}), 64'(0));
        if (mon_vc == 1) begin
          mon_snap_addr = out_addr;
          mon_snap_rest = {out_fmt_type, out_len, out_first_be, out_last_be, out_write, 4'h0};
        end else begin
          chk("out_addr_stable", 64'(out_addr), 64'(mon_snap_addr));
          chk("out_fields_stable",
              64'({out_fmt_type, out_len, out_first_be, out_last_be, out_write, 4'h0}),
              64'(mon_snap_rest));
        end
        if (mon_vc > rdy_delay) begin
          out_ready = 1'b1;
          chk("sb_nonempty", 64'(exp_q.size() > 0), 64'(1));
          if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("fmt_type", 64'(out_fmt_type), 64'(e.fmt));
            chk("len", 64'(out_len), 64'(e.len));
            chk("first_be", 64'(out_first_be), 64'(e.fbe));
            chk("last_be", 64'(out_last_be), 64'(e.lbe));
            chk("addr", 64'(out_addr), 64'(e.addr));
            chk("write", 64'(out_write), 64'(e.wr));
            $display("out cmd: fmt=%02h len=%0d fbe=%h lbe=%h addr=%h wr=%0d",
                     out_fmt_type, out_len, out_first_be, out_last_be, out_addr, out_write);
          end
          n_out++;
          mon_vc = 0;
          mon_pend_idle = 1'b1;
        end else begin
          out_ready = 1'b0;
        end
      end else begin
        mon_vc = 0;
        out_ready = 1'b0;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the handshake.
  task automatic send(input bit is_wr, input logic [29:0] a, input logic [3:0] len,
                      input logic [3:0] fbe, input logic [3:0] lbe,
                      input bit push, input bit hold);
    bit got = 1'b0;
    if (push) exp_q.push_back(mk(is_wr, a, len, fbe, lbe));
    if (is_wr) begin
      wr_if.valid = 1'b1; wr_if.addr = a; wr_if.len = len;
      wr_if.first_be = fbe; wr_if.last_be = lbe;
    end else begin
      rd_if.valid = 1'b1; rd_if.addr = a; rd_if.len = len;
      rd_if.first_be = fbe; rd_if.last_be = lbe;
    end
    for (int i = 0; i < 300; i++) begin
      #1;
      if (is_wr ? wr_if.ready : rd_if.ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("send_accepted", 64'(got), 64'(1));
    $display("cmd %s addr=%h len=%0d accepted=%0d", is_wr ? "WR" : "RD", a, len, got);
    @(negedge clk);
    if (!hold) begin
      if (is_wr) wr_if.valid = 1'b0;
      else rd_if.valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0 && !out_valid && !trans_req) break;
      @(negedge clk);
    end
    chk("drain", 64'(exp_q.size()), 64'(0));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n0;
    wr_if.valid = 1'b1; wr_if.addr = '0; wr_if.len = 4'd1;
    wr_if.first_be = 4'h0; wr_if.last_be = 4'h0;
    rd_if.valid = 1'b1; rd_if.addr = '0; rd_if.len = 4'd1;
    rd_if.first_be = 4'h0; rd_if.last_be = 4'h0;

    // Reset state, with both requesters valid so ready gating is exercised.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    chk("rst_trans_req", 64'(trans_req), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_ready", 64'({wr_if.ready, rd_if.ready}), 64'(0));
    @(negedge clk);
    wr_if.valid = 1'b0;
    rd_if.valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single 32-bit write
    tr_off = 62'h2000_0000; tr_64 = 1'b0; tr_delay = 2;
    send(1'b1, 30'h400, 4'd4, 4'hF, 4'h3, 1'b1, 1'b0);
    drain();

    // 2: 64-bit single-DW read
    tr_off = 62'h4000_0000; tr_64 = 1'b1;
    send(1'b0, 30'h10, 4'd1, 4'hF, 4'hF, 1'b1, 1'b0);
    drain();

    // 3: both sides continuously valid, expect W,R,W,R...
    tr_off = 62'h100; tr_64 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(mk(1'b1, 30'h1000 + 30'(k), 4'(k + 1), 4'hE, 4'h7));
      exp_q.push_back(mk(1'b0, 30'h2000 + 30'(k), 4'(k + 2), 4'hC, 4'h1));
    end
    fork
      for (int k = 0; k < 4; k++)
        send(1'b1, 30'h1000 + 30'(k), 4'(k + 1), 4'hE, 4'h7, 1'b0, k < 3);
      for (int k = 0; k < 4; k++)
        send(1'b0, 30'h2000 + 30'(k), 4'(k + 2), 4'hC, 4'h1, 1'b0, k < 3);
    join
    drain();

    // 4: translator stalls 20 cycles
    tr_off = 62'h0; tr_64 = 1'b0; tr_delay = 20;
    n0 = n_out;
    send(1'b0, 30'h3_1234, 4'd15, 4'h1, 4'h8, 1'b1, 1'b0);
    drain();
    chk("one_out_cmd", 64'(n_out - n0), 64'(1));
    tr_delay = 2;

    // 5: out_ready held low 10 cycles, second command waiting
    rdy_delay = 10;
    send(1'b1, 30'h55, 4'd2, 4'h6, 4'h9, 1'b1, 1'b0);
    send(1'b1, 30'h66, 4'd3, 4'hF, 4'hF, 1'b1, 1'b0);
    rdy_delay = 0;
    drain();

    // 6a: reset during XLAT
    tr_delay = 10;
    send(1'b1, 30'h77, 4'd2, 4'hF, 4'hF, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #3;
    chk("rst_xlat_trans_req", 64'(trans_req), 64'(0));
    chk("rst_xlat_out_valid", 64'(out_valid), 64'(0));
    rst_n = 1'b1;
    void'(exp_q.pop_back());
    tr_delay = 2;
    @(negedge clk);

    // 6b: reset during OUT
    rdy_delay = 1000;
    send(1'b0, 30'h88, 4'd3, 4'hF, 4'hF, 1'b1, 1'b0);
    for (int i = 0; i < 50; i++) begin
      if (out_valid) break;
      @(negedge clk);
    end
    chk("reached_out", 64'(out_valid), 64'(1));
    rst_n = 1'b0;
    @(negedge clk);
    #3;
    chk("rst_out_trans_req", 64'(trans_req), 64'(0));
    chk("rst_out_out_valid", 64'(out_valid), 64'(0));
    rst_n = 1'b1;
    void'(exp_q.pop_back());
    rdy_delay = 0;
    @(negedge clk);

    // clean transaction after resets
    tr_off = 62'h1_0000; tr_64 = 1'b0;
    send(1'b1, 30'h99, 4'd5, 4'h3, 4'hC, 1'b1, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
